// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It resolves
//   load-use hazards, EXE-stage branch redirects and multi-cycle data-memory
//   accesses, and keeps a saturating count of PC-stall cycles for debug.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rs1_id/rs2_id            source register indices of the ID instruction
//   rs1_used_id/rs2_used_id  ID instruction actually reads rs1/rs2
//   rd_exe, mem_read_exe     destination and load flag of the EXE instruction
//   valid_exe                EXE slot holds a valid instruction
//   branch_taken_exe         EXE redirects the PC (taken branch/jump)
//   mem_access_mem, mem_ack  load/store in MEM and its completion strobe
//   mem_req                  request to data memory
//   stall_*/flush_*          hold/bubble controls for PC and stage registers
//   mem_err                  sticky data-access timeout error
//   stall_cycles             saturating count of cycles with stall_pc high
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_exe,
    input  logic             mem_read_exe,
    input  logic             valid_exe,
    input  logic             branch_taken_exe,
    input  logic             mem_access_mem,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idexe,
    output logic             stall_exemem,
    output logic             flush_ifid,
    output logic             flush_idexe,
    output logic             flush_memwb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WCNT_W-1:0] waitCnt_q;
    logic              memErr_q;
    logic [CNT_W-1:0]  stallCycles_q;

    logic memWait;
    logic loadUse;

    // Hazard decode and the fixed-priority control row. Everything is forced
    // low while reset is held, even though the inputs may still be toggling.
    // Stall and flush are never both raised for the same stage register.
    always_comb begin
        mem_req      = 1'b0;
        memWait      = 1'b0;
        loadUse      = 1'b0;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idexe  = 1'b0;
        stall_exemem = 1'b0;
        flush_ifid   = 1'b0;
        flush_idexe  = 1'b0;
        flush_memwb  = 1'b0;
        if (!rst) begin
            mem_req = mem_access_mem && (state_q != ERR);
            memWait = mem_req && !mem_ack;
            loadUse = valid_exe && mem_read_exe && (rd_exe != 5'd0) &&
                      ((rs1_used_id && (rs1_id == rd_exe)) ||
                       (rs2_used_id && (rs2_id == rd_exe)));
            if (state_q == ERR) begin
                stall_pc     = 1'b1;
                stall_ifid   = 1'b1;
                stall_idexe  = 1'b1;
                stall_exemem = 1'b1;
                flush_memwb  = 1'b1;
            end else if (memWait) begin
                // EXE is frozen, so branch and load-use are re-evaluated later.
                stall_pc     = 1'b1;
                stall_ifid   = 1'b1;
                stall_idexe  = 1'b1;
                stall_exemem = 1'b1;
                flush_memwb  = 1'b1;
            end else if (branch_taken_exe) begin
                // The ID instruction is squashed, so any load-use is moot.
                flush_ifid  = 1'b1;
                flush_idexe = 1'b1;
            end else if (loadUse) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                flush_idexe = 1'b1;
            end
        end
    end

    // Data-access FSM, wait counter, sticky error and the stall counter.
    // The wait counter holds the number of stalled cycles already spent on
    // the current access; the cycle that would reach TIMEOUT moves to ERR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            waitCnt_q     <= '0;
            memErr_q      <= 1'b0;
            stallCycles_q <= '0;
        end else begin
            if (stall_pc && (stallCycles_q != '1)) begin
                stallCycles_q <= stallCycles_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (memWait) begin
                        state_q   <= WAIT;
                        waitCnt_q <= WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_ack || !mem_access_mem) begin
                        state_q   <= IDLE;
                        waitCnt_q <= '0;
                    end else if (waitCnt_q == WCNT_W'(TIMEOUT - 1)) begin
                        state_q   <= ERR;
                        memErr_q  <= 1'b1;
                        waitCnt_q <= waitCnt_q + WCNT_W'(1);
                    end else begin
                        waitCnt_q <= waitCnt_q + WCNT_W'(1);
                    end
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q   <= IDLE;
                    waitCnt_q <= '0;
                end
            endcase
        end
    end

    assign mem_err      = memErr_q;
    assign stall_cycles = stallCycles_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall and flush inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers, plus the PC hold.
- Resolves load-use hazards, EXE-stage branch redirects and multi-cycle data-memory accesses through a req/ack FSM with timeout.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
TIMEOUT, 64, max consecutive wait cycles on a data access before entering ERR (must be >= 2)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rs1_id  in  5  rs1 index of instruction in ID
rs2_id  in  5  rs2 index of instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rd_exe  in  5  destination register of instruction in EXE
mem_read_exe  in  1  EXE instruction is a load
valid_exe  in  1  EXE slot holds a valid instruction
branch_taken_exe  in  1  EXE resolved a taken branch/jump (redirect)
mem_access_mem  in  1  valid load/store present in MEM
mem_ack  in  1  data memory completes the access this cycle
mem_req  out  1  request to data memory
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID
stall_idexe  out  1  hold ID/EXE
stall_exemem  out  1  hold EXE/MEM
flush_ifid  out  1  bubble IF/ID
flush_idexe  out  1  bubble ID/EXE
flush_memwb  out  1  bubble MEM/WB
mem_err  out  1  sticky timeout error
stall_cycles  out  CNT_W  cycles with stall_pc=1, saturating

Behaviour:
- FSM states: IDLE, WAIT, ERR. Reset (asynchronous, any time, including mid-WAIT) -> IDLE, wait counter 0, mem_err 0, stall_cycles 0. All outputs are 0 while rst is high.
- Stall/flush/mem_req outputs are combinational from current state and inputs, taking effect at the same clock edge. mem_err and stall_cycles are registered.
- mem_req = mem_access_mem when state is IDLE or WAIT; 0 in ERR.
- mem_wait = mem_req & ~mem_ack.
- IDLE:
  - mem_wait -> WAIT, wait counter = 1.
  - ack in the same cycle as the request -> stay IDLE; zero-latency access costs no stall.
- WAIT:
  - mem_ack -> IDLE, counter cleared.
  - else counter += 1; when counter reaches TIMEOUT -> ERR and mem_err <= 1.
  - mem_access_mem dropping without an ack (a flush upstream is illegal here) -> IDLE.
- ERR: stall_pc, stall_ifid, stall_idexe and stall_exemem held at 1 and flush_memwb at 1 until reset.
- Load-use hazard: load_use = valid_exe & mem_read_exe & rd_exe != 0 & ((rs1_used_id & rs1_id == rd_exe) | (rs2_used_id & rs2_id == rd_exe)).
- Priority, highest first; exactly one row applies per cycle:
  1. ERR: as above.
  2. mem_wait: stall_pc = stall_ifid = stall_idexe = stall_exemem = 1, flush_memwb = 1. branch_taken_exe and load_use are ignored; they are re-evaluated once the wait ends because EXE is frozen.
  3. branch_taken_exe: flush_ifid = flush_idexe = 1, no stalls; the PC loads the target. Any simultaneous load_use is suppressed because the ID instruction is squashed.
  4. load_use: stall_pc = stall_ifid = 1, flush_idexe = 1. This is a 1-cycle bubble; next cycle the load has moved to MEM and load_use is naturally 0.
  5. Otherwise: all stall/flush = 0.
- Whenever a stall is asserted on a register, the flush for that same register is 0; stall and flush are never both driven to one register.
- stall_cycles increments on every clock edge where stall_pc = 1 and saturates at all-ones. It is cleared only by reset.

Test Plan:
1. Load x5 in EXE, ID reads rs2=x5 with rs2_used_id=1 -> one cycle of stall_pc = stall_ifid = flush_idexe = 1; next cycle all 0; stall_cycles = 1.
2. Same as 1 but rd_exe = 0 or valid_exe = 0 -> no stall or flush; stall_cycles = 0.
3. branch_taken_exe = 1 together with load_use = 1 -> flush_ifid = flush_idexe = 1, stall_pc = 0, stall_cycles unchanged.
4. mem_access_mem = 1, mem_ack held low 3 cycles and high on the 4th -> mem_req = 1 for 4 cycles; stall_pc/ifid/idexe/exemem and flush_memwb = 1 for 3 cycles; FSM IDLE->WAIT->IDLE; stall_cycles = 3. A pending branch_taken_exe is applied on the ack cycle.
5. TIMEOUT = 4, mem_ack never asserted -> ERR after 4 wait cycles, mem_err = 1, mem_req = 0, stalls held. Asserting rst returns IDLE with mem_err = 0 and all outputs 0.
6. Assert rst asynchronously mid-WAIT (between clock edges) -> outputs go to 0 immediately; after release, mem_access_mem with same-cycle ack -> no stall.
